// File: rtl/mips_shift_pipe.sv
// mips_shift_pipe: pipelined barrel shifter for SLL / SRL / SRA / ROR.
//
// The shift is split into SHW = log2(WIDTH) registered stages. Stage k
// shifts by 2^k when bit k of the amount is set and otherwise passes the
// data through, so a result leaves SHW cycles after it is accepted.
// The pipeline uses one global stall: when the output is valid and not
// consumed, every stage holds and the input is refused.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation presented
//   in_ready   operation accepted this cycle (= !stall)
//   in_data    operand, WIDTH bits
//   in_amount  shift distance, SHW bits
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_tag     sideband returned unchanged with the result
//   out_valid  result present
//   out_ready  consumer accepts the result
//   out_data   result, WIDTH bits
//   out_tag    tag of the result
module mips_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amount,
  input  logic [1:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // Result path: every stage carries valid, data and tag.
  logic [SHW-1:0]   valid_q, valid_d;
  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [TAG_W-1:0] tag_q  [SHW];
  logic [TAG_W-1:0] tag_d  [SHW];

  // Control path: only stages that still feed a later shift need the
  // amount, op and sign, so the final stage holds just the result.
  logic [SHW-1:0]   amt_q  [SHW-1];
  logic [SHW-1:0]   amt_d  [SHW-1];
  logic [1:0]       op_q   [SHW-1];
  logic [1:0]       op_d   [SHW-1];
  logic [SHW-2:0]   sign_q, sign_d;

  // Inputs seen by each stage: the ports for stage 0, the previous
  // stage register otherwise.
  logic [SHW-1:0]   src_valid;
  logic [WIDTH-1:0] src_data [SHW];
  logic [TAG_W-1:0] src_tag  [SHW];
  logic [SHW-1:0]   src_amt  [SHW];
  logic [1:0]       src_op   [SHW];
  logic [SHW-1:0]   src_sign;

  logic stall;

  // One step of the shifter by distance s (s < WIDTH).
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sign,
    input int               s
  );
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> s) : '0;
    case (op)
      OP_SLL:  shift_step = d << s;
      OP_SRL:  shift_step = d >> s;
      OP_SRA:  shift_step = (d >> s) | fill;
      default: shift_step = (d >> s) | (d << (WIDTH - s));
    endcase
  endfunction

  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_tag   = tag_q[SHW-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_tag[0]   = in_tag;
    src_amt[0]   = in_amount;
    src_op[0]    = in_op;
    // The sign is captured once at acceptance and only for SRA.
    src_sign[0]  = (in_op == OP_SRA) ? in_data[WIDTH-1] : 1'b0;
    for (int k = 1; k < SHW; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_tag[k]   = tag_q[k-1];
      src_amt[k]   = amt_q[k-1];
      src_op[k]    = op_q[k-1];
      src_sign[k]  = sign_q[k-1];
    end

    for (int k = 0; k < SHW; k++) begin
      valid_d[k] = src_valid[k];
      tag_d[k]   = src_tag[k];
      data_d[k]  = src_amt[k][k]
                   ? shift_step(src_data[k], src_op[k], src_sign[k], 1 << k)
                   : src_data[k];
    end

    for (int k = 0; k < SHW - 1; k++) begin
      amt_d[k]  = src_amt[k];
      op_d[k]   = src_op[k];
      sign_d[k] = src_sign[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sign_q  <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
      for (int k = 0; k < SHW - 1; k++) begin
        amt_q[k] <= '0;
        op_q[k]  <= '0;
      end
    end else if (!stall) begin
      // Bubbles move with the data; nothing is collapsed.
      valid_q <= valid_d;
      sign_q  <= sign_d;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= data_d[k];
        tag_q[k]  <= tag_d[k];
      end
      for (int k = 0; k < SHW - 1; k++) begin
        amt_q[k] <= amt_d[k];
        op_q[k]  <= op_d[k];
      end
    end
  end

endmodule

// File: tb/tb_mips_shift_pipe.sv
module tb_mips_shift_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int SHW   = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [4:0]       in_amount;
  logic [1:0]       in_op;
  logic [3:0]       in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [3:0]       out_tag;

  int errors = 0;
  int checks = 0;

  // Expected results in acceptance order.
  logic [31:0] exp_d[$];
  logic [3:0]  exp_t[$];

  logic        stall_prev;
  logic [31:0] held_d;
  logic [3:0]  held_t;

  mips_shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic on wide words.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a,
                                            input logic [1:0] op);
    logic [63:0] w;
    case (op)
      2'b00: ref_shift = d << a;
      2'b01: ref_shift = d >> a;
      2'b10: begin w = {{32{d[31]}}, d}; w = w >> a; ref_shift = w[31:0]; end
      default: begin w = {d, d}; w = w >> a; ref_shift = w[31:0]; end
    endcase
  endfunction

  // Scoreboard: all signals stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_d.delete();
      exp_t.delete();
      stall_prev = 1'b0;
    end else begin
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL in_ready_rule: in_ready=%b out_valid=%b out_ready=%b",
                 in_ready, out_valid, out_ready);
      end
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h t=%h, want v=1 d=%h t=%h",
                   out_valid, out_data, out_tag, held_d, held_t);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got d=%h t=%h, want none", out_data, out_tag);
        end else begin
          logic [31:0] ed;
          logic [3:0]  et;
          ed = exp_d.pop_front();
          et = exp_t.pop_front();
          if (out_data !== ed || out_tag !== et) begin
            errors++;
            $display("FAIL result: got d=%h t=%h, want d=%h t=%h",
                     out_data, out_tag, ed, et);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_d.push_back(ref_shift(in_data, int'(in_amount), in_op));
        exp_t.push_back(in_tag);
      end
      stall_prev = out_valid && !out_ready;
      held_d = out_data;
      held_t = out_tag;
    end
  end

  // Presents one op and returns at posedge+1 after the edge that took it.
  task automatic send(input logic [31:0] d, input logic [4:0] a,
                      input logic [1:0] op, input logic [3:0] tag);
    bit rdy;
    rdy = 0;
    in_valid = 1'b1; in_data = d; in_amount = a; in_op = op; in_tag = tag;
    for (int g = 0; g < 50 && !rdy; g++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL send_timeout: got no acceptance in 50 cycles, want acceptance");
    end
  endtask

  task automatic wait_drain(input string name);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (exp_d.size() == 0 && out_valid === 1'b0) break;
    end
    checks++;
    if (exp_d.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending v=%b, want 0 pending v=0",
               name, exp_d.size(), out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_directed(input string name, input logic [31:0] d,
                              input logic [4:0] a, input logic [1:0] op,
                              input logic [3:0] tag, input logic [31:0] expd);
    int lat;
    bit seen;
    out_ready = 1'b1;
    send(d, a, op, tag);
    in_valid = 1'b0;
    seen = 0;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen || lat != SHW) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles (seen=%0d), want %0d", name, lat, seen, SHW);
    end
    checks++;
    if (out_data !== expd) begin
      errors++;
      $display("FAIL %s_data: got %h, want %h", name, out_data, expd);
    end
    checks++;
    if (out_tag !== tag) begin
      errors++;
      $display("FAIL %s_tag: got %h, want %h", name, out_tag, tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_amount = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h t=%h rdy=%b, want v=0 d=0 t=0 rdy=1",
               out_valid, out_data, out_tag, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_directed("sll31",  32'h0000_0001, 5'd31, 2'b00, 4'd3, 32'h8000_0000);
    run_directed("sra4",   32'h8000_0000, 5'd4,  2'b10, 4'd1, 32'hF800_0000);
    run_directed("srl31",  32'h8000_0000, 5'd31, 2'b01, 4'd2, 32'h0000_0001);
    run_directed("sra31p", 32'h7FFF_FFFF, 5'd31, 2'b10, 4'd4, 32'h0000_0000);
    run_directed("ror8",   32'h1234_5678, 5'd8,  2'b11, 4'd5, 32'h7812_3456);
    run_directed("ror0",   32'h1234_5678, 5'd0,  2'b11, 4'd6, 32'h1234_5678);
    run_directed("sra0",   32'h8000_0000, 5'd0,  2'b10, 4'd7, 32'h8000_0000);
    run_directed("sra31n", 32'h8000_0000, 5'd31, 2'b10, 4'd8, 32'hFFFF_FFFF);
  endtask

  task automatic test_back_to_back();
    bit seen;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'(i));
    in_valid = 1'b0;
    seen = 0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_start: got no out_valid in 20 cycles, want out_valid");
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 4'(i)) begin
        errors++;
        $display("FAIL b2b_seq: got v=%b t=%0d, want v=1 t=%0d", out_valid, out_tag, i);
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got v=%b after 5 results, want v=0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [31:0] hd;
    logic [3:0]  ht;
    out_ready = 1'b1;
    send(32'hA5A5_0F0F, 5'd3, 2'b00, 4'd5);
    send(32'h8000_00F0, 5'd7, 2'b10, 4'd6);
    send(32'hDEAD_BEEF, 5'd12, 2'b11, 4'd7);
    in_valid = 1'b0;
    for (int g = 0; g < 20; g++) begin
      if (out_valid === 1'b1) break;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    hd = out_data;
    ht = out_tag;
    checks++;
    if (out_valid !== 1'b1 || ht !== 4'd5) begin
      errors++;
      $display("FAIL stall_head: got v=%b t=%0d, want v=1 t=5", out_valid, ht);
    end
    in_valid = 1'b1; in_data = 32'h0000_1234; in_amount = 5'd4; in_op = 2'b01; in_tag = 4'd8;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready: got %b, want 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht) begin
        errors++;
        $display("FAIL stall_frozen: got v=%b d=%h t=%h, want v=1 d=%h t=%h",
                 out_valid, out_data, out_tag, hd, ht);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain("stall");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_amount = 5'($urandom_range(0, 31));
      in_op     = 2'($urandom_range(0, 3));
      in_tag    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    wait_drain("random");
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1;
    send(32'h0000_00FF, 5'd1, 2'b00, 4'd9);
    send(32'hF000_0000, 5'd2, 2'b10, 4'd10);
    send(32'h0F0F_0F0F, 5'd4, 2'b11, 4'd11);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_precond: got v=%b, want v=1 before reset", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_async: got v=%b d=%h t=%h rdy=%b, want v=0 d=0 t=0 rdy=1",
               out_valid, out_data, out_tag, in_ready);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_stale: got v=%b t=%h, want v=0", out_valid, out_tag);
      end
    end
    @(posedge clk); #1;
    run_directed("after_reset", 32'h0000_0003, 5'd30, 2'b00, 4'd12, 32'hC000_0000);
  endtask

  initial begin
    stall_prev = 1'b0;
    held_d = '0;
    held_t = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, want completion");
    $fatal(1, "timeout");
  end

endmodule
